// File: rtl/exec_decode_unit.sv
// Decode, ALU and branch-resolution stage for the RV32I core.
// Decode controls feed the operand muxes in the same cycle; results are registered once.
module exec_decode_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm_ext,
  output logic [2:0]  imm_src,
  output logic [31:0] alu_res_q,
  output logic        next_pc_src_q,
  output logic        ru_wr_q,
  output logic        dm_wr_q,
  output logic [2:0]  dm_ctrl_q,
  output logic [1:0]  ru_data_wr_src_q,
  output logic [31:0] pc_plus4_q,
  output logic [31:0] rs2_data_q,
  output logic        out_valid
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0010: r = {31'd0, $signed(a) < $signed(b)};
      4'b0011: r = {31'd0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $unsigned($signed(a) >>> b[4:0]);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1001: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic br_taken_f(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic t;
    case (op[4:3])
      2'b00: t = 1'b0;
      2'b01: t = 1'b1;
      2'b10: begin
        case (op[2:0])
          3'b000:  t = (a == b);
          3'b001:  t = (a != b);
          3'b100:  t = ($signed(a) < $signed(b));
          3'b101:  t = ($signed(a) >= $signed(b));
          3'b110:  t = (a < b);
          3'b111:  t = (a >= b);
          default: t = 1'b0;
        endcase
      end
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic        f7b5_s;
  logic        ru_wr_s, dm_wr_s, a_src_s, b_src_s;
  logic [2:0]  imm_src_s, dm_ctrl_s;
  logic [3:0]  alu_op_s;
  logic [4:0]  br_op_s;
  logic [1:0]  wr_src_s;
  logic [31:0] op_a_s, op_b_s, alu_res_s;
  logic        taken_s;
  logic        unused_s;

  assign opcode_s = inst[6:0];
  assign f3_s     = inst[14:12];
  assign f7b5_s   = inst[30];
  assign unused_s = ^{inst[31], inst[29:15], inst[11:7]};

  // Opcode decode into datapath controls; unknown opcodes leave everything at zero.
  always_comb begin
    ru_wr_s   = 1'b0;
    dm_wr_s   = 1'b0;
    a_src_s   = 1'b0;
    b_src_s   = 1'b0;
    imm_src_s = 3'b000;
    alu_op_s  = ALU_ADD;
    br_op_s   = 5'b00000;
    wr_src_s  = 2'b00;
    dm_ctrl_s = 3'b000;
    case (opcode_s)
      OP_R: begin
        ru_wr_s  = 1'b1;
        alu_op_s = {f7b5_s, f3_s};
      end
      OP_I: begin
        ru_wr_s  = 1'b1;
        b_src_s  = 1'b1;
        alu_op_s = {(f3_s == 3'b101) ? f7b5_s : 1'b0, f3_s};
      end
      OP_LOAD: begin
        ru_wr_s   = 1'b1;
        b_src_s   = 1'b1;
        wr_src_s  = 2'b01;
        dm_ctrl_s = f3_s;
      end
      OP_STORE: begin
        dm_wr_s   = 1'b1;
        b_src_s   = 1'b1;
        imm_src_s = 3'b001;
        dm_ctrl_s = f3_s;
      end
      OP_BR: begin
        a_src_s   = 1'b1;
        b_src_s   = 1'b1;
        imm_src_s = 3'b101;
        br_op_s   = {2'b10, f3_s};
      end
      OP_JAL: begin
        ru_wr_s   = 1'b1;
        a_src_s   = 1'b1;
        b_src_s   = 1'b1;
        imm_src_s = 3'b110;
        br_op_s   = 5'b01000;
        wr_src_s  = 2'b10;
      end
      // JALR target is the raw sum; bit 0 is deliberately left as computed.
      OP_JALR: begin
        ru_wr_s  = 1'b1;
        b_src_s  = 1'b1;
        br_op_s  = 5'b01000;
        wr_src_s = 2'b10;
      end
      OP_LUI: begin
        ru_wr_s   = 1'b1;
        b_src_s   = 1'b1;
        imm_src_s = 3'b010;
        alu_op_s  = ALU_PASSB;
      end
      OP_AUIPC: begin
        ru_wr_s   = 1'b1;
        a_src_s   = 1'b1;
        b_src_s   = 1'b1;
        imm_src_s = 3'b010;
      end
      default: begin
        ru_wr_s = 1'b0;
      end
    endcase
  end

  assign imm_src   = imm_src_s;
  assign op_a_s    = a_src_s ? pc : rs1_data;
  assign op_b_s    = b_src_s ? imm_ext : rs2_data;
  assign alu_res_s = alu_f(alu_op_s, op_a_s, op_b_s);
  assign taken_s   = br_taken_f(br_op_s, rs1_data, rs2_data);

  // Execute/write-back pipeline register; invalid slots suppress only the state-changing enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res_q        <= 32'd0;
      next_pc_src_q    <= 1'b0;
      ru_wr_q          <= 1'b0;
      dm_wr_q          <= 1'b0;
      dm_ctrl_q        <= 3'd0;
      ru_data_wr_src_q <= 2'd0;
      pc_plus4_q       <= 32'd0;
      rs2_data_q       <= 32'd0;
      out_valid        <= 1'b0;
    end else begin
      alu_res_q        <= alu_res_s;
      next_pc_src_q    <= taken_s & in_valid;
      ru_wr_q          <= ru_wr_s & in_valid;
      dm_wr_q          <= dm_wr_s & in_valid;
      dm_ctrl_q        <= dm_ctrl_s;
      ru_data_wr_src_q <= wr_src_s;
      pc_plus4_q       <= pc + 32'd4;
      rs2_data_q       <= rs2_data;
      out_valid        <= in_valid;
    end
  end

endmodule

// File: tb/tb_exec_decode_unit.sv
// Scoreboard bench for exec_decode_unit: a stimulus process queues expected results
// from an instruction-level reference model, and a monitor compares them after each edge.
module tb_exec_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst, pc, rs1_data, rs2_data, imm_ext;
  logic [2:0]  imm_src;
  logic [31:0] alu_res_q;
  logic        next_pc_src_q, ru_wr_q, dm_wr_q;
  logic [2:0]  dm_ctrl_q;
  logic [1:0]  ru_data_wr_src_q;
  logic [31:0] pc_plus4_q, rs2_data_q;
  logic        out_valid;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        npc;
    logic        ru;
    logic        dm;
    logic [2:0]  ctrl;
    logic [1:0]  src;
    logic [31:0] pc4;
    logic [31:0] rs2;
    logic        v;
  } exp_t;

  exp_t q[$];

  exec_decode_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ext(imm_ext), .imm_src(imm_src),
    .alu_res_q(alu_res_q), .next_pc_src_q(next_pc_src_q), .ru_wr_q(ru_wr_q),
    .dm_wr_q(dm_wr_q), .dm_ctrl_q(dm_ctrl_q), .ru_data_wr_src_q(ru_data_wr_src_q),
    .pc_plus4_q(pc_plus4_q), .rs2_data_q(rs2_data_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Register-register / register-immediate arithmetic by mnemonic.
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (f3)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << sh;
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? $unsigned($signed(x) >>> sh) : x >> sh;
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [2:0] model_imm_src(input logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return 3'b000;
      7'b0100011:                         return 3'b001;
      7'b1100011:                         return 3'b101;
      7'b0110111, 7'b0010111:             return 3'b010;
      7'b1101111:                         return 3'b110;
      default:                            return 3'b000;
    endcase
  endfunction

  function automatic exp_t model(input logic v, input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im);
    exp_t e;
    logic [2:0] f3;
    f3 = i[14:12];
    e.res = a + b; e.npc = 1'b0; e.ru = 1'b0; e.dm = 1'b0; e.ctrl = 3'd0; e.src = 2'd0;
    e.pc4 = p + 32'd4; e.rs2 = b; e.v = v;
    case (i[6:0])
      7'b0110011: begin e.res = arith(f3, i[30], a, b); e.ru = 1'b1; end
      7'b0010011: begin e.res = arith(f3, (f3 == 3'd5) && i[30], a, im); e.ru = 1'b1; end
      7'b0000011: begin e.res = a + im; e.ru = 1'b1; e.src = 2'b01; e.ctrl = f3; end
      7'b0100011: begin e.res = a + im; e.dm = 1'b1; e.ctrl = f3; end
      7'b1100011: begin
        e.res = p + im;
        case (f3)
          3'd0: e.npc = (a == b);
          3'd1: e.npc = (a != b);
          3'd4: e.npc = ($signed(a) < $signed(b));
          3'd5: e.npc = ($signed(a) >= $signed(b));
          3'd6: e.npc = (a < b);
          3'd7: e.npc = (a >= b);
          default: e.npc = 1'b0;
        endcase
      end
      7'b1101111: begin e.res = p + im; e.npc = 1'b1; e.ru = 1'b1; e.src = 2'b10; end
      7'b1100111: begin e.res = a + im; e.npc = 1'b1; e.ru = 1'b1; e.src = 2'b10; end
      7'b0110111: begin e.res = im; e.ru = 1'b1; end
      7'b0010111: begin e.res = p + im; e.ru = 1'b1; end
      default: e.res = a + b;
    endcase
    if (!v) begin
      e.ru = 1'b0; e.dm = 1'b0; e.npc = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = v; inst = i; pc = p; rs1_data = a; rs2_data = b; imm_ext = im;
    if (mon_en) q.push_back(model(v, i, p, a, b, im));
    #1 chk("imm_src", {29'd0, imm_src}, {29'd0, model_imm_src(i)});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_res"}, alu_res_q, 32'd0);
    chk({tag, "_ctrl"}, {26'd0, next_pc_src_q, ru_wr_q, dm_wr_q, out_valid, ru_data_wr_src_q}, 32'd0);
    chk({tag, "_dm_ctrl"}, {29'd0, dm_ctrl_q}, 32'd0);
    chk({tag, "_pc4"}, pc_plus4_q, 32'd0);
    chk({tag, "_rs2"}, rs2_data_q, 32'd0);
  endtask

  // Monitor: pops one expectation per captured slot and compares every registered output.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && q.size() != 0) begin
      e = q.pop_front();
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      chk("alu_res_q", alu_res_q, e.res);
      chk("next_pc_src_q", {31'd0, next_pc_src_q}, {31'd0, e.npc});
      chk("ru_wr_q", {31'd0, ru_wr_q}, {31'd0, e.ru});
      chk("dm_wr_q", {31'd0, dm_wr_q}, {31'd0, e.dm});
      chk("dm_ctrl_q", {29'd0, dm_ctrl_q}, {29'd0, e.ctrl});
      chk("wr_src_q", {30'd0, ru_data_wr_src_q}, {30'd0, e.src});
      chk("pc_plus4_q", pc_plus4_q, e.pc4);
      chk("rs2_data_q", rs2_data_q, e.rs2);
    end
  end

  initial begin
    logic [6:0] illegal_ops [4];
    illegal_ops[0] = 7'b0000000; illegal_ops[1] = 7'b1111111;
    illegal_ops[2] = 7'b0001111; illegal_ops[3] = 7'b1110011;
    rst_n = 1'b1;
    in_valid = 1'b0; inst = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; imm_ext = 32'd0;
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset_init");
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    drive(1'b1, enc(7'b0100000, 3'b000, 7'b0110011), 32'h0, 32'd5, 32'd7, 32'd0);
    drive(1'b1, enc(7'b0100000, 3'b101, 7'b0110011), 32'h4, 32'h80000000, 32'd4, 32'd0);
    drive(1'b1, enc(7'b0000000, 3'b010, 7'b0110011), 32'h8, 32'hFFFFFFFF, 32'd1, 32'd0);
    drive(1'b1, enc(7'b0000000, 3'b011, 7'b0110011), 32'hC, 32'hFFFFFFFF, 32'd1, 32'd0);
    drive(1'b1, enc(7'b0000000, 3'b100, 7'b1100011), 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
    drive(1'b1, enc(7'b0000000, 3'b110, 7'b1100011), 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
    drive(1'b1, enc(7'b0000000, 3'b000, 7'b1100111), 32'h40, 32'h1000, 32'd9, 32'd8);
    drive(1'b1, enc(7'b0000000, 3'b010, 7'b0000011), 32'h44, 32'h100, 32'd9, 32'd4);
    drive(1'b1, enc(7'b0000000, 3'b000, 7'b0000000), 32'h48, 32'd3, 32'd4, 32'd8);
    drive(1'b0, enc(7'b0000000, 3'b000, 7'b1101111), 32'h4C, 32'd3, 32'd4, 32'd8);
    drive(1'b0, enc(7'b0000000, 3'b010, 7'b0100011), 32'h50, 32'd3, 32'd4, 32'd8);
    drive(1'b1, enc(7'b0000000, 3'b000, 7'b0110111), 32'h54, 32'd3, 32'd4, 32'h12345000);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #3;
    mon_en = 1'b0;
    drive(1'b1, enc(7'b0000000, 3'b000, 7'b1101111), 32'h200, 32'd1, 32'd2, 32'h10);
    @(posedge clk);
    #2 chk("pre_reset_ru_wr", {31'd0, ru_wr_q}, 32'd1);
    rst_n = 1'b0;
    #1 chk_all_zero("reset_mid");
    mon_en = 1'b1;
    drive(1'b1, enc(7'b0100000, 3'b000, 7'b0110011), 32'h300, 32'd20, 32'd5, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] i, a, b, im, p;
      logic v;
      int kind;
      logic [2:0] f3;
      kind = int'($urandom_range(0, 9));
      f3 = 3'($urandom_range(0, 7));
      i = $urandom;
      case (kind)
        0: i = enc(((f3 == 3'd0) || (f3 == 3'd5)) ? {1'b0, 1'($urandom_range(0, 1)), 5'd0} : 7'd0,
                   f3, 7'b0110011);
        1: i = {i[31:15], f3, i[11:7], 7'b0010011};
        2: i = {i[31:15], f3, i[11:7], 7'b0000011};
        3: i = {i[31:15], f3, i[11:7], 7'b0100011};
        4: i = {i[31:15], f3, i[11:7], 7'b1100011};
        5: i = {i[31:7], 7'b1101111};
        6: i = {i[31:15], 3'b000, i[11:7], 7'b1100111};
        7: i = {i[31:7], 7'b0110111};
        8: i = {i[31:7], 7'b0010111};
        default: i = {i[31:7], illegal_ops[$urandom_range(0, 3)]};
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {a[31], 31'($urandom_range(0, 3))};
      im = $urandom;
      p = $urandom;
      v = ($urandom_range(0, 7) != 0);
      drive(v, i, p, a, b, im);
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #3 chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
